// File: rtl/mem_wb_bridge_pkg.sv
// Shared widths, FSM state type and latched request context for the bridge.
package mem_wb_bridge_pkg;

  localparam int unsigned WB_ADDR_W = 30;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = WB_DATA_W / 8;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned RLEN_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Request fields that live for the whole transaction
  typedef struct packed {
    logic [RLEN_W-1:0] rlen;
    logic [ID_W-1:0]   id;
    logic              rmw;
  } req_ctx_t;

endpackage

// File: rtl/mem_wb_bridge_if.sv
// Core memory port plus Wishbone-classic master signals of the bridge.
interface mem_wb_bridge_if;
  import mem_wb_bridge_pkg::*;

  // Core memory request / response
  logic                 request;
  logic [WB_ADDR_W-1:0] addr;
  logic [RLEN_W-1:0]    rlen;
  logic                 rnw;
  logic                 rmw;
  logic [ID_W-1:0]      id;
  logic [WB_SEL_W-1:0]  wbe;
  logic [WB_DATA_W-1:0] wdata;
  logic                 ack;
  logic                 rvalid;
  logic [WB_DATA_W-1:0] rdata;
  logic [ID_W-1:0]      rid;
  logic                 inv;
  logic [WB_ADDR_W-1:0] inv_addr;
  logic                 write_outstanding;

  // Wishbone bus
  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic                 wb_lock;
  logic [WB_SEL_W-1:0]  wb_sel;
  logic [WB_ADDR_W-1:0] wb_adr;
  logic [WB_DATA_W-1:0] wb_dat_w;
  logic                 wb_ack;
  logic                 wb_err;
  logic [WB_DATA_W-1:0] wb_dat_r;

  // Bridge view
  modport slave (
    input  request, addr, rlen, rnw, rmw, id, wbe, wdata,
    input  wb_ack, wb_err, wb_dat_r,
    output ack, rvalid, rdata, rid, inv, inv_addr, write_outstanding,
    output wb_cyc, wb_stb, wb_we, wb_lock, wb_sel, wb_adr, wb_dat_w
  );

  // Environment view (arbiter + Wishbone slave)
  modport master (
    output request, addr, rlen, rnw, rmw, id, wbe, wdata,
    output wb_ack, wb_err, wb_dat_r,
    input  ack, rvalid, rdata, rid, inv, inv_addr, write_outstanding,
    input  wb_cyc, wb_stb, wb_we, wb_lock, wb_sel, wb_adr, wb_dat_w
  );

endinterface

// File: rtl/mem_wb_bridge_beat_timer.sv
// Per-beat wait counter; expire_o rises once LIMIT strobe cycles elapse without a clear.
module wb_beat_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Next count and expiry flag
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expire_d = !clear_i && (cnt_d == CNT_W'(LIMIT));
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/mem_wb_bridge.sv
// Expands arbitrated read bursts / single writes into Wishbone-classic single-word cycles.
module mem_wb_bridge
  import mem_wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          INCLUDE_LOCK   = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mem_wb_bridge_if.slave bus
);

  state_e               state_q, state_d;
  req_ctx_t             ctx_q, ctx_d;
  logic [RLEN_W-1:0]    beat_q, beat_d;

  logic                 rvalid_q, rvalid_d;
  logic [WB_DATA_W-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]      rid_q, rid_d;
  logic                 wout_q, wout_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic                 lock_q, lock_d;
  logic [WB_SEL_W-1:0]  sel_q, sel_d;
  logic [WB_ADDR_W-1:0] adr_q, adr_d;
  logic [WB_DATA_W-1:0] dat_w_q, dat_w_d;

  logic accept_c, done_c, last_c, data_ok_c, expire, timer_clear;

  // Request handshake and beat completion (ack+err together counts as err)
  assign accept_c    = rst && bus.request && (state_q == IDLE);
  assign done_c      = (state_q != IDLE) && (bus.wb_ack || bus.wb_err || expire);
  assign last_c      = (state_q == WRITE) || (beat_q == ctx_q.rlen);
  assign data_ok_c   = bus.wb_ack && !bus.wb_err;
  assign timer_clear = accept_c || done_c;

  // Optional per-beat timeout
  generate
    if (TIMEOUT_CYCLES != 0) begin : g_timer
      wb_beat_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (timer_clear),
        .en_i     (cyc_q),
        .expire_o (expire)
      );
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (accept_c) state_d = bus.rnw ? READ : WRITE;
      READ, WRITE: if (done_c && last_c) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Next values of latched context and registered outputs
  always_comb begin
    ctx_d    = ctx_q;
    beat_d   = beat_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    dat_w_d  = dat_w_q;
    if (accept_c) begin
      ctx_d   = '{rlen: bus.rlen, id: bus.id, rmw: bus.rmw};
      beat_d  = '0;
      adr_d   = bus.addr;
      sel_d   = bus.rnw ? {WB_SEL_W{1'b1}} : bus.wbe;
      dat_w_d = bus.wdata;
    end
    if (done_c && (state_q == READ)) begin
      rvalid_d = 1'b1;
      rid_d    = ctx_q.id;
      rdata_d  = data_ok_c ? bus.wb_dat_r : '0;
      beat_d   = beat_q + RLEN_W'(1);
      adr_d    = adr_q + WB_ADDR_W'(1);
    end
    cyc_d  = (state_d != IDLE);
    we_d   = (state_d == WRITE);
    wout_d = (state_d == WRITE);
    lock_d = INCLUDE_LOCK && (state_d != IDLE) && ctx_d.rmw;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctx_q    <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      wout_q   <= 1'b0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      lock_q   <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_w_q  <= '0;
    end else begin
      ctx_q    <= ctx_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      wout_q   <= wout_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      lock_q   <= lock_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      dat_w_q  <= dat_w_d;
    end
  end

  assign bus.ack               = accept_c;
  assign bus.rvalid            = rvalid_q;
  assign bus.rdata             = rdata_q;
  assign bus.rid               = rid_q;
  assign bus.write_outstanding = wout_q;
  assign bus.wb_cyc            = cyc_q;
  assign bus.wb_stb            = cyc_q;
  assign bus.wb_we             = we_q;
  assign bus.wb_lock           = lock_q;
  assign bus.wb_sel            = sel_q;
  assign bus.wb_adr            = adr_q;
  assign bus.wb_dat_w          = dat_w_q;
  assign bus.inv               = 1'b0;
  assign bus.inv_addr          = '0;

endmodule

// File: tb/tb_mem_wb_bridge.sv
// Directed scoreboard bench for mem_wb_bridge with a programmable Wishbone slave.
module tb_mem_wb_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_bridge_if bus ();

  mem_wb_bridge #(.TIMEOUT_CYCLES(8), .INCLUDE_LOCK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
  } exp_t;

  exp_t        exp_q[$];
  logic [29:0] exp_adr_q[$];
  int          rv_cycles[$];

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // Slave model controls
  bit          slave_en    = 1'b1;
  bit          slave_err   = 1'b0;
  bit          slave_fixed = 1'b0;
  logic [31:0] slave_data  = 32'h0;
  int          slave_delay = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Wishbone slave: answers each beat after slave_delay wait cycles
  initial begin
    int wcnt;
    wcnt = 0;
    bus.wb_ack   = 1'b0;
    bus.wb_err   = 1'b0;
    bus.wb_dat_r = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (bus.wb_ack || bus.wb_err) wcnt = 0;
      bus.wb_ack = 1'b0;
      bus.wb_err = 1'b0;
      if (bus.wb_cyc && bus.wb_stb && slave_en) begin
        if (wcnt == slave_delay) begin
          bus.wb_ack   = 1'b1;
          bus.wb_err   = slave_err;
          bus.wb_dat_r = slave_fixed ? slave_data : (32'(bus.wb_adr) ^ 32'hC0DE_0000);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every rvalid and checks beat addresses
  initial begin
    exp_t        e;
    logic [29:0] a;
    forever begin
      @(posedge clk); #3;
      if (bus.rvalid) begin
        rv_cycles.push_back(cyc_n);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid: got rdata %h rid %0d expected no rvalid (cycle %0d)",
                   bus.rdata, bus.rid, cyc_n);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", bus.rdata, e.data);
          chk("rid", 32'(bus.rid), 32'(e.id));
        end
      end
      if (bus.wb_cyc && bus.wb_stb && bus.wb_ack && exp_adr_q.size() != 0) begin
        a = exp_adr_q.pop_front();
        chk("wb_adr", 32'(bus.wb_adr), 32'(a));
      end
    end
  end

  // Advance to the #3 sample point of period p
  task automatic wait_period(input int p);
    int guard;
    guard = 0;
    while (cyc_n < p && guard < 1000) begin
      @(posedge clk); #3;
      guard++;
    end
  endtask

  // Present a request until acked; returns the period in which ack was high
  task automatic issue(input logic rnw_, input logic [29:0] a, input logic [4:0] len,
                       input logic [1:0] i, input logic m, input logic [3:0] be,
                       input logic [31:0] d, output int ack_at);
    int n;
    n = 0;
    @(negedge clk);
    bus.request = 1'b1;
    bus.rnw     = rnw_;
    bus.addr    = a;
    bus.rlen    = len;
    bus.id      = i;
    bus.rmw     = m;
    bus.wbe     = be;
    bus.wdata   = d;
    #1;
    while (!bus.ack && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ack_seen", 32'(bus.ack), 32'd1);
    ack_at = cyc_n;
    @(posedge clk); #1;
    bus.request = 1'b0;
    #2;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #3;
      n++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
    repeat (2) begin @(posedge clk); #3; end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [1:0] i);
    exp_t e;
    e.data = d;
    e.id   = i;
    exp_q.push_back(e);
  endtask

  int a0, a1;
  logic cyc_s [1:6];
  logic lock_s[1:6];
  logic we_s  [1:6];

  initial begin
    rst         = 1'b0;
    bus.request = 1'b1;
    bus.rnw     = 1'b1;
    bus.addr    = '0;
    bus.rlen    = '0;
    bus.id      = '0;
    bus.rmw     = 1'b0;
    bus.wbe     = '0;
    bus.wdata   = '0;

    // Reset: ack suppressed even with request high, outputs cleared
    repeat (3) @(posedge clk);
    #3;
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_cyc", 32'(bus.wb_cyc), 32'd0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset_wout", 32'(bus.write_outstanding), 32'd0);
    chk("inv", 32'(bus.inv), 32'd0);
    chk("inv_addr", 32'(bus.inv_addr), 32'd0);
    bus.request = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Single read, slave acks 2 cycles after stb
    slave_fixed = 1'b1; slave_data = 32'hDEAD_BEEF; slave_delay = 2;
    rv_cycles.delete();
    push_exp(32'hDEAD_BEEF, 2'b01);
    issue(1'b1, 30'h100, 5'd0, 2'b01, 1'b0, 4'h0, 32'h0, a0);
    chk("rd_cyc1", 32'(bus.wb_cyc), 32'd1);
    chk("rd_stb1", 32'(bus.wb_stb), 32'd1);
    chk("rd_we", 32'(bus.wb_we), 32'd0);
    chk("rd_sel", 32'(bus.wb_sel), 32'hF);
    chk("rd_adr", 32'(bus.wb_adr), 32'h100);
    chk("rd_lock", 32'(bus.wb_lock), 32'd0);
    wait_period(a0 + 3);
    chk("rd_cyc3", 32'(bus.wb_cyc), 32'd1);
    wait_period(a0 + 4);
    chk("rd_cyc4", 32'(bus.wb_cyc), 32'd0);
    drain("rd_drain");
    chk("rd_rv_cnt", 32'(rv_cycles.size()), 32'd1);
    if (rv_cycles.size() == 1) chk("rd_rv_time", 32'(rv_cycles[0] - a0), 32'd4);
    slave_fixed = 1'b0;

    // Burst wrapping the top of the address space, zero-wait slave
    slave_delay = 0;
    rv_cycles.delete();
    exp_adr_q.push_back(30'h3FFF_FFFE);
    exp_adr_q.push_back(30'h3FFF_FFFF);
    exp_adr_q.push_back(30'h0);
    exp_adr_q.push_back(30'h1);
    push_exp(32'hFF21_FFFE, 2'b10);
    push_exp(32'hFF21_FFFF, 2'b10);
    push_exp(32'hC0DE_0000, 2'b10);
    push_exp(32'hC0DE_0001, 2'b10);
    issue(1'b1, 30'h3FFF_FFFE, 5'd3, 2'b10, 1'b0, 4'h0, 32'h0, a0);
    for (int k = 1; k <= 4; k++) begin
      wait_period(a0 + k);
      chk("burst_stb", 32'(bus.wb_stb), 32'd1);
    end
    drain("burst_drain");
    chk("burst_adr_left", 32'(exp_adr_q.size()), 32'd0);
    chk("burst_rv_cnt", 32'(rv_cycles.size()), 32'd4);
    if (rv_cycles.size() == 4) begin
      chk("burst_rv_first", 32'(rv_cycles[0] - a0), 32'd2);
      chk("burst_rv_span", 32'(rv_cycles[3] - rv_cycles[0]), 32'd3);
    end

    // Single write
    slave_delay = 1;
    rv_cycles.delete();
    issue(1'b0, 30'h0ABC, 5'd7, 2'b11, 1'b0, 4'b0011, 32'h1234_5678, a0);
    chk("wr_we", 32'(bus.wb_we), 32'd1);
    chk("wr_sel", 32'(bus.wb_sel), 32'h3);
    chk("wr_dat", bus.wb_dat_w, 32'h1234_5678);
    chk("wr_adr", 32'(bus.wb_adr), 32'h0ABC);
    chk("wr_wout1", 32'(bus.write_outstanding), 32'd1);
    wait_period(a0 + 2);
    chk("wr_wout2", 32'(bus.write_outstanding), 32'd1);
    wait_period(a0 + 3);
    chk("wr_wout3", 32'(bus.write_outstanding), 32'd0);
    chk("wr_cyc3", 32'(bus.wb_cyc), 32'd0);
    drain("wr_drain");
    chk("wr_no_rvalid", 32'(rv_cycles.size()), 32'd0);

    // Locked read followed by a pending write
    push_exp(32'hC0DE_0200, 2'b10);
    issue(1'b1, 30'h200, 5'd0, 2'b10, 1'b1, 4'h0, 32'h0, a0);
    fork
      issue(1'b0, 30'h204, 5'd0, 2'b00, 1'b0, 4'hF, 32'hCAFE_F00D, a1);
      for (int k = 1; k <= 6; k++) begin
        wait_period(a0 + k);
        cyc_s[k]  = bus.wb_cyc;
        lock_s[k] = bus.wb_lock;
        we_s[k]   = bus.wb_we;
      end
    join
    chk("b2b_ack_gap", 32'(a1 - a0), 32'd3);
    chk("rmw_lock1", 32'(lock_s[1]), 32'd1);
    chk("rmw_lock2", 32'(lock_s[2]), 32'd1);
    chk("b2b_gap_cyc", 32'(cyc_s[3]), 32'd0);
    chk("b2b_wr_cyc", 32'(cyc_s[4]), 32'd1);
    chk("b2b_wr_we", 32'(we_s[4]), 32'd1);
    chk("b2b_wr_lock", 32'(lock_s[4]), 32'd0);
    drain("b2b_drain");

    // Timeout: slave silent, each beat forced after 8 wait cycles
    slave_en = 1'b0;
    rv_cycles.delete();
    push_exp(32'h0, 2'b11);
    push_exp(32'h0, 2'b11);
    issue(1'b1, 30'h40, 5'd1, 2'b11, 1'b0, 4'h0, 32'h0, a0);
    drain("to_drain");
    chk("to_rv_cnt", 32'(rv_cycles.size()), 32'd2);
    if (rv_cycles.size() == 2) begin
      chk("to_rv0_time", 32'(rv_cycles[0] - a0), 32'd10);
      chk("to_rv1_time", 32'(rv_cycles[1] - a0), 32'd19);
    end
    chk("to_idle_cyc", 32'(bus.wb_cyc), 32'd0);
    slave_en = 1'b1;

    // ack and err together complete as an error
    slave_delay = 0;
    slave_err   = 1'b1;
    push_exp(32'h0, 2'b10);
    issue(1'b1, 30'h9, 5'd0, 2'b10, 1'b0, 4'h0, 32'h0, a0);
    drain("err_drain");
    slave_err = 1'b0;

    // Reset during beat 2 of an 8-beat burst
    rv_cycles.delete();
    push_exp(32'hC0DE_0500, 2'b00);
    push_exp(32'hC0DE_0501, 2'b00);
    issue(1'b1, 30'h500, 5'd7, 2'b00, 1'b0, 4'h0, 32'h0, a0);
    wait_period(a0 + 3);
    @(negedge clk);
    rst = 1'b0;
    wait_period(a0 + 4);
    chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_wout", 32'(bus.write_outstanding), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin @(posedge clk); #3; end
    chk("rst_rv_cnt", 32'(rv_cycles.size()), 32'd2);
    push_exp(32'hC0DE_0007, 2'b01);
    issue(1'b1, 30'h7, 5'd0, 2'b01, 1'b0, 4'h0, 32'h0, a0);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on simulation time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion (checks %0d failures %0d)", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
